// File: rtl/qam_mod_param_if.sv
// External bit-stream handshake into the QAM modulator.
interface qam_mod_param_if;
  logic s_bit;
  logic s_valid;
  logic s_ready;

  modport master (output s_bit, output s_valid, input s_ready);
  modport slave  (input s_bit, input s_valid, output s_ready);
endinterface

// File: rtl/qam_mod_param.sv
// 4/16-QAM modulator: PN or external bit source, Gray symbol mapper,
// NCO with quarter-wave-offset sine table and a 3-stage I/Q mixing pipeline.
module qam_mod_param #(
  parameter int BIT_DIV = 4,
  parameter int AMP_W   = 10,
  parameter int PHASE_W = 12,
  parameter int LUT_AW  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      src_sel,
  qam_mod_param_if.slave            s_if,
  input  logic [PHASE_W-1:0]        fcw,
  output logic signed [2:0]         sym_i,
  output logic signed [2:0]         sym_q,
  output logic                      sym_strobe,
  output logic                      underrun,
  output logic signed [AMP_W+3:0]   qam
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam int LUT_N = 2 ** LUT_AW;
  localparam longint HALF_N  = longint'(LUT_N / 2);
  localparam longint QUART_N = longint'(LUT_N / 4);
  localparam longint PI_Q30  = 64'sd3373259426;

  // Table entry round(A*sin(2*pi*n/N)) in Q30 fixed point, folded to the first quadrant.
  function automatic logic signed [AMP_W-1:0] sin_entry(input int n);
    longint m;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint amp;
    longint val;
    logic   neg;
    m   = longint'(n);
    neg = 1'b0;
    if (m >= HALF_N) begin
      neg = 1'b1;
      m   = m - HALF_N;
    end
    if (m > QUART_N) begin
      m = HALF_N - m;
    end
    x    = (64'sd2 * PI_Q30 * m) / longint'(LUT_N);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k < 9; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      acc  = acc + term;
    end
    amp = (64'sd1 <<< (AMP_W - 1)) - 64'sd1;
    val = (acc * amp + (64'sd1 <<< 29)) >>> 30;
    if (neg) begin
      val = -val;
    end
    return val[AMP_W-1:0];
  endfunction

  function automatic logic signed [2:0] gray_level(input logic [1:0] b);
    logic signed [2:0] lvl;
    case (b)
      2'b00:   lvl = 3'sb101;
      2'b01:   lvl = 3'sb111;
      2'b11:   lvl = 3'sb001;
      2'b10:   lvl = 3'sb011;
      default: lvl = 3'sb000;
    endcase
    return lvl;
  endfunction

  logic signed [AMP_W-1:0] sin_lut_s [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic signed [AMP_W-1:0] LUT_VAL = sin_entry(g);
    assign sin_lut_s[g] = LUT_VAL;
  end

  logic [CNT_W-1:0]          cnt_r;
  logic [2:0]                lfsr_r;
  logic [3:0]                coll_r;
  logic [1:0]                bcnt_r;
  logic                      sym_mode_r;
  logic [PHASE_W-1:0]        phase_r;
  logic signed [AMP_W-1:0]   sin_r;
  logic signed [AMP_W-1:0]   cos_r;
  logic signed [2:0]         lvl_i_r;
  logic signed [2:0]         lvl_q_r;
  logic signed [AMP_W+2:0]   i_mod_r;
  logic signed [AMP_W+2:0]   q_mod_r;

  logic                      bit_tick_s;
  logic                      new_bit_s;
  logic                      eff_mode_s;
  logic [3:0]                coll_next_s;
  logic                      sym_done_s;
  logic signed [2:0]         lvl_i_s;
  logic signed [2:0]         lvl_q_s;
  logic [LUT_AW-1:0]         addr_s;
  logic [LUT_AW-1:0]         cos_addr_s;

  // Reset gates the tick so no handshake is offered while held in reset.
  assign bit_tick_s   = rst & en & (cnt_r == CNT_LAST);
  assign s_if.s_ready = bit_tick_s & src_sel;
  assign new_bit_s    = src_sel ? (s_if.s_valid & s_if.s_bit) : lfsr_r[2];
  assign eff_mode_s   = (bcnt_r == 2'd0) ? mode : sym_mode_r;
  assign coll_next_s  = {coll_r[2:0], new_bit_s};
  assign sym_done_s   = bit_tick_s & (bcnt_r == (eff_mode_s ? 2'd3 : 2'd1));
  assign addr_s       = phase_r[PHASE_W-1 -: LUT_AW];
  assign cos_addr_s   = addr_s + LUT_AW'(LUT_N / 4);

  // Map the collector (including the bit arriving now) to I/Q levels.
  always_comb begin
    lvl_i_s = 3'sb000;
    lvl_q_s = 3'sb000;
    if (eff_mode_s) begin
      lvl_i_s = gray_level(coll_next_s[3:2]);
      lvl_q_s = gray_level(coll_next_s[1:0]);
    end else begin
      lvl_i_s = coll_next_s[1] ? 3'sb011 : 3'sb101;
      lvl_q_s = coll_next_s[0] ? 3'sb011 : 3'sb101;
    end
  end

  // Bit timing, PN source, symbol collection and level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r      <= '0;
      lfsr_r     <= 3'b001;
      coll_r     <= 4'd0;
      bcnt_r     <= 2'd0;
      sym_mode_r <= 1'b0;
      sym_i      <= 3'sb000;
      sym_q      <= 3'sb000;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else if (en) begin
      cnt_r      <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
      sym_strobe <= sym_done_s;
      if (bit_tick_s) begin
        if (!src_sel) begin
          lfsr_r <= {lfsr_r[1:0], lfsr_r[2] ^ lfsr_r[1]};
        end
        if (src_sel && !s_if.s_valid) begin
          underrun <= 1'b1;
        end
        if (bcnt_r == 2'd0) begin
          sym_mode_r <= mode;
        end
        if (sym_done_s) begin
          coll_r <= 4'd0;
          bcnt_r <= 2'd0;
          sym_i  <= lvl_i_s;
          sym_q  <= lvl_q_s;
        end else begin
          coll_r <= coll_next_s;
          bcnt_r <= bcnt_r + 2'd1;
        end
      end
    end
  end

  // NCO and mixer; levels ride along stage 1 so they align with the carrier.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_r <= '0;
      sin_r   <= '0;
      cos_r   <= '0;
      lvl_i_r <= 3'sb000;
      lvl_q_r <= 3'sb000;
      i_mod_r <= '0;
      q_mod_r <= '0;
      qam     <= '0;
    end else if (en) begin
      phase_r <= phase_r + fcw;
      sin_r   <= sin_lut_s[addr_s];
      cos_r   <= sin_lut_s[cos_addr_s];
      lvl_i_r <= sym_i;
      lvl_q_r <= sym_q;
      i_mod_r <= (AMP_W+3)'(lvl_i_r) * (AMP_W+3)'(cos_r);
      q_mod_r <= (AMP_W+3)'(lvl_q_r) * (AMP_W+3)'(sin_r);
      qam     <= (AMP_W+4)'(i_mod_r) - (AMP_W+4)'(q_mod_r);
    end
  end

endmodule

// File: tb/tb_qam_mod_param.sv
// Directed scoreboard bench for qam_mod_param (BIT_DIV=4 main unit, BIT_DIV=1 PN unit).
module tb_qam_mod_param;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, mode, src_sel;
  logic [11:0]        fcw;
  logic signed [2:0]  sym_i, sym_q;
  logic               sym_strobe, underrun;
  logic signed [13:0] qam;

  logic               rst1, en1, zero1;
  logic [11:0]        fcw1;
  logic signed [2:0]  sym_i1, sym_q1;
  logic               sym_strobe1, underrun1;
  logic signed [13:0] qam1;

  qam_mod_param_if bus ();
  qam_mod_param_if bus1 ();

  qam_mod_param #(.BIT_DIV(4), .AMP_W(10), .PHASE_W(12), .LUT_AW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .src_sel(src_sel), .s_if(bus.slave),
    .fcw(fcw), .sym_i(sym_i), .sym_q(sym_q), .sym_strobe(sym_strobe),
    .underrun(underrun), .qam(qam));

  qam_mod_param #(.BIT_DIV(1), .AMP_W(10), .PHASE_W(12), .LUT_AW(8)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(zero1), .src_sel(zero1), .s_if(bus1.slave),
    .fcw(fcw1), .sym_i(sym_i1), .sym_q(sym_q1), .sym_strobe(sym_strobe1),
    .underrun(underrun1), .qam(qam1));

  // Reference phase accumulator for the main unit.
  logic [11:0] ph_m;
  always @(posedge clk) begin
    if (!rst) ph_m <= 12'd0;
    else if (en) ph_m <= ph_m + fcw;
  end

  typedef struct { int i; int q; } sym_t;
  sym_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] pn_bits = 7'b0010111;

  function automatic int sin_m(input int n);
    real v;
    v = 511.0 * $sin(2.0 * PI * real'(n) / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int qam_m(input int li, input int lq);
    logic [11:0] p;
    int a;
    p = ph_m - fcw - fcw - fcw;
    a = int'(p[11:4]);
    return li * sin_m((a + 64) % 256) - lq * sin_m(a);
  endfunction

  function automatic int pn_lvl(input int idx);
    return pn_bits[6 - (idx % 7)] ? 3 : -3;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input int q);
    sym_t e;
    e.i = i;
    e.q = q;
    exp_q.push_back(e);
  endtask

  task automatic check_sym(input string tag, input bit sel);
    sym_t e;
    int k;
    logic stb;
    k = 0;
    @(negedge clk);
    stb = sel ? sym_strobe1 : sym_strobe;
    while (stb !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      stb = sel ? sym_strobe1 : sym_strobe;
    end
    chk({tag, "_strobe"}, stb, 1);
    chk({tag, "_pending"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_i"}, sel ? sym_i1 : sym_i, e.i);
      chk({tag, "_q"}, sel ? sym_q1 : sym_q, e.q);
    end
  endtask

  task automatic send_bit(input bit b, input bit v);
    int k;
    bus.s_bit   = b;
    bus.s_valid = v;
    k = 0;
    @(negedge clk);
    while (bus.s_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("s_ready_wait", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_bit   = 1'b0;
  endtask

  task automatic rst_main();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 1'b1; src_sel = 1'b1; fcw = 12'd0;
    bus.s_bit = 1'b0; bus.s_valid = 1'b0;
    rst1 = 1'b0; en1 = 1'b1; zero1 = 1'b0; fcw1 = 12'd0;
    bus1.s_bit = 1'b0; bus1.s_valid = 1'b0;

    // Reset held with enable high.
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_sym_i", sym_i, 0);
    chk("rst_sym_q", sym_q, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_qam", qam, 0);

    // PN source, one bit per clock, 4-QAM.
    @(posedge clk);
    #1 rst1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      push(pn_lvl(2 * k), pn_lvl(2 * k + 1));
      check_sym("pn", 1'b1);
    end
    @(posedge clk);
    #1 en1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("pn_frz_strobe", sym_strobe1, 0);
      chk("pn_frz_i", sym_i1, 3);
    end
    @(posedge clk);
    #1 en1 = 1'b1;
    for (int k = 7; k < 13; k++) begin
      push(pn_lvl(2 * k), pn_lvl(2 * k + 1));
      check_sym("pn_resume", 1'b1);
    end

    // 16-QAM external bits 1,0,1,1 with fcw = 0.
    @(posedge clk);
    #1 rst = 1'b1;
    push(3, 1);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    check_sym("q16", 1'b0);
    chk("q16_qam_strobe", qam, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("q16_qam_e2", qam, 0);
    chk("q16_strobe_pulse", sym_strobe, 0);
    @(posedge clk); @(negedge clk);
    chk("q16_qam_e3", qam, 1533);
    rst_main();

    // 4-QAM streaming, then a mode change after the first bit of a symbol.
    mode = 1'b0;
    push(3, -3);  send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); check_sym("q4a", 1'b0);
    push(-3, 3);  send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); check_sym("q4b", 1'b0);
    push(-3, -3); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1); check_sym("q4c", 1'b0);
    mode = 1'b1;
    push(-1, 3);
    send_bit(1'b0, 1'b1);
    mode = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    check_sym("mode_old", 1'b0);
    push(3, 3);   send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); check_sym("mode_new", 1'b0);
    chk("no_underrun", underrun, 0);
    rst_main();

    // Missing external bit inserts a zero and sets the sticky flag.
    chk("urun_clear", underrun, 0);
    push(3, -3);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    chk("urun_set", underrun, 1);
    check_sym("urun_sym", 1'b0);
    push(3, 3);   send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); check_sym("urun_next", 1'b0);
    chk("urun_sticky", underrun, 1);

    // Running NCO, then a 10-cycle freeze in the middle of a symbol.
    fcw = 12'h0A5;
    rst_main();
    push(3, 3);   send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); check_sym("nco_a", 1'b0);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    chk("nco_qam_a", qam, qam_m(3, 3));
    en = 1'b0;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frz_qam", qam, qam_m(3, 3));
      chk("frz_strobe", sym_strobe, 0);
      chk("frz_s_ready", bus.s_ready, 0);
      chk("frz_sym_i", sym_i, 3);
    end
    en = 1'b1;
    bus.s_valid = 1'b0;
    push(-3, 3);  send_bit(1'b1, 1'b1); check_sym("nco_b", 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
    chk("nco_qam_b", qam, qam_m(-3, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qam_mod_param.md
QAM_MOD_PARAM -- requirements
Module: qam_mod_param

Interface
REQ-001 Parameter: BIT_DIV, 4, clk cycles per data bit (>=1).
REQ-002 Parameter: AMP_W, 10, signed carrier sample width.
REQ-003 Parameter: PHASE_W, 12, NCO phase accumulator width.
REQ-004 Parameter: LUT_AW, 8, carrier table address width (<=PHASE_W).
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  synchronous, active-low reset.
REQ-007 Port: en  input  1  global clock enable.
REQ-008 Port: mode  input  1  0 = 4-QAM (2 bits/symbol), 1 = 16-QAM (4 bits/symbol).
REQ-009 Port: src_sel  input  1  0 = internal PN source, 1 = external bit stream.
REQ-010 Port: s_bit / s_valid  input  1 / 1  external bit and its valid.
REQ-011 Port: s_ready  output  1  external bit accepted this cycle when s_valid high.
REQ-012 Port: fcw  input  PHASE_W  NCO frequency control word.
REQ-013 Port: sym_i / sym_q  output  3 / 3  signed I/Q levels.
REQ-014 Port: sym_strobe  output  1  one-cycle pulse when new levels load.
REQ-015 Port: underrun  output  1  sticky flag, external bit missing at bit tick.
REQ-016 Port: qam  output  AMP_W+4  signed modulated sample.

Function
REQ-017 en low SHALL freeze every counter, LFSR, NCO and pipeline register; outputs hold; s_ready = 0.
REQ-018 Bit counter SHALL count 0..BIT_DIV-1 while en; bit_tick asserts when count = BIT_DIV-1 and en.
REQ-019 Internal PN: 3-bit Fibonacci LFSR, x^3+x^2+1, shift left, new LSB = q[2]^q[1], output bit = q[2], advances only on bit_tick with src_sel = 0.
REQ-020 s_ready SHALL equal bit_tick & src_sel; with s_valid high the bit is s_bit; with s_valid low a 0 is inserted and underrun sets.
REQ-021 Bits SHALL shift into a 4-bit collector MSB-first; symbol complete after 2 bits (mode 0) or 4 bits (mode 1).
REQ-022 mode SHALL be sampled at the first bit tick of each symbol and held for that symbol; mid-symbol changes take effect on the next symbol.
REQ-023 src_sel SHALL switch only at the next bit tick; a partial symbol is not discarded.
REQ-024 Mapping mode 0: first bit -> I, second -> Q; 0 -> -3, 1 -> +3.
REQ-025 Mapping mode 1: bits[3:2] -> I, bits[1:0] -> Q, Gray: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
REQ-026 sym_i/sym_q SHALL register one cycle after the completing bit tick, with sym_strobe high that cycle.
REQ-027 NCO: phase += fcw modulo 2^PHASE_W each enabled cycle; address = phase[PHASE_W-1 -: LUT_AW].
REQ-028 sin[n] = round((2^(AMP_W-1)-1)*sin(2*pi*n/2^LUT_AW)); cos uses address + 2^(LUT_AW-2), wrapping.
REQ-029 Pipeline: stage 1 registers sin/cos; stage 2 registers i_mod = sym_i*cos and q_mod = sym_q*sin (AMP_W+3 bits); stage 3 registers qam = i_mod - q_mod, full precision, no saturation.
REQ-030 Latency: a phase value or level change SHALL reach qam 3 enabled cycles later.

Reset
REQ-031 While rst low at a clk edge: counters, phase, collector, pipeline = 0; LFSR = 3'b001; sym_i = sym_q = 0; sym_strobe, s_ready, underrun, qam = 0.
REQ-032 Reset SHALL override en and abort any partial symbol; the first bit after release is the first bit of a new symbol.
REQ-033 underrun SHALL clear only on reset.

Verification
REQ-034 Reset held with en = 1 -> all outputs 0; release -> qam stays 0 until the first sym_strobe.
REQ-035 BIT_DIV = 1, src_sel = 0, mode = 0 -> PN bits 0,0,1,0,1,1,1 repeating with period 7; first symbol I = -3, Q = -3.
REQ-036 fcw = 0, mode = 1, external bits 1,0,1,1 -> sym_i = +3, sym_q = +1; with AMP_W = 10, qam = 3*511 = 1533 three cycles after strobe.
REQ-037 src_sel = 1, s_valid low at one bit tick -> 0 inserted, underrun rises and remains high.
REQ-038 mode toggled after the first bit of a symbol -> current symbol uses the old bit count; the next symbol uses the new one.
REQ-039 en low for 10 cycles mid-symbol -> all outputs, phase and LFSR unchanged; resumes exactly where it stopped.
